mic_sample_filter: RTL and testbench
====================================

MIC_SAMPLE_FILTER -- requirements
Module: mic_sample_filter

Interface
REQ-001 Parameter AVG_LOG2, default 3, log2 of moving-average depth (range 1..5).
REQ-002 Parameter DATA_W, default 12, sample width.
REQ-003 clock  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 inValid  in  1  one-cycle strobe; inData holds a new mic sample (driven from capture DONE).
REQ-006 inData  in  DATA_W  unsigned offset-binary mic sample.
REQ-007 outStart  out  1  one-cycle pulse requesting a DAC conversion of outData.
REQ-008 outData  out  DATA_W  filtered sample; stable from outStart until dacDone.
REQ-009 dacDone  in  1  DAC finished the current conversion.
REQ-010 overrun  out  1  sticky; a sample was dropped.

Function
REQ-011 FSM states: IDLE, ACCUM, ISSUE, WAIT; reset state IDLE.
REQ-012 Sample accepted when inValid=1 and (state=IDLE, or state=WAIT with dacDone=1); acceptance moves to ACCUM.
REQ-013 inValid in ACCUM, ISSUE, or WAIT without dacDone: sample dropped, overrun set to 1.
REQ-014 ACCUM: ring buffer of 2^AVG_LOG2 entries overwrites oldest with new sample; sum <= sum + new - oldest; write pointer wraps modulo depth; next ISSUE.
REQ-015 Accumulator width DATA_W+AVG_LOG2; no overflow possible; average = sum >> AVG_LOG2 (truncate).
REQ-016 ISSUE: outData loaded with filtered value, outStart=1 for exactly this cycle; next WAIT.
REQ-017 WAIT: dacDone=1 returns to IDLE, or to ACCUM if REQ-012 accepts a sample the same cycle.
REQ-018 dacDone outside WAIT ignored.
REQ-019 Latency: sample accepted at cycle t gives outStart at t+2.
REQ-020 Buffer starts all-zero; first 2^AVG_LOG2-1 outputs reflect zero-filled history (no fill gating).

Reset
REQ-021 Reset clears sum, ring contents, pointer, outData, outStart, overrun to 0; state to IDLE; DC estimate per REQ-024.
REQ-022 Reset mid-WAIT abandons the pending conversion; next dacDone ignored.

Configuration
REQ-023 Macro MIC_SAMPLE_FILTER_DC_BLOCK_EN selects the DC-blocking stage.
REQ-024 Defined: dcEst (DATA_W+8 bits, reset 2048<<8) updates in ACCUM as dcEst + avg - (dcEst>>8); filtered = avg - (dcEst>>8) + 2048, clamped to 0..4095.
REQ-025 Undefined: filtered = avg; no dcEst register exists.

Structure
REQ-026 Package mic_pkg holds DATA_W default, MIDSCALE=2048, DC_SHIFT=8, FSM state type.
REQ-027 Ring buffer plus pointer is sub-module mic_sample_ring (write-enable, write data, read-oldest data).

Verification
REQ-028 No macro, AVG_LOG2=3: eight samples of 800, each after dacDone -> outData 100,200,...,800; outStart 2 cycles after each inValid.
REQ-029 Second inValid 1 cycle after first, before dacDone -> second dropped, overrun=1, only one outStart.
REQ-030 In WAIT, inValid with dacDone same cycle -> sample accepted, outStart 2 cycles later, overrun stays 0.
REQ-031 Macro defined: constant 3000 input for 2000 samples -> outData converges to 2048 +/-4 and never exceeds 4095.
REQ-032 Reset asserted in WAIT, then dacDone -> state IDLE, outData=0, no outStart; next sample gives outData = sample>>3.
REQ-033 11th sample after ten of 4095 -> sum wraps oldest correctly; outData = 4095.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared constants and FSM state type for the microphone sample filter.
package mic_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int MIDSCALE   = 2048;
    localparam int DC_SHIFT   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_ISSUE,
        ST_WAIT
    } mic_state_e;

endpackage

// File: rtl/mic_sample_ring.sv
// Moving-average history: 2^DEPTH_LOG2 samples, write pointer always addresses the oldest entry.
module mic_sample_ring #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_W     = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_oldest_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] ptr_q;

    // NOTE: the history is flop-based and reset to zero on purpose, because the
    // running sum assumes an all-zero history; a RAM without reset would break that.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[ptr_q] <= wr_data_i;
            ptr_q        <= ptr_q + DEPTH_LOG2'(1);
        end
    end

    assign rd_oldest_o = mem_q[ptr_q];

endmodule

// File: rtl/mic_sample_filter.sv
// Mic sample moving-average filter feeding a DAC handshake.
// Optional DC-blocking stage enabled by defining MIC_SAMPLE_FILTER_DC_BLOCK_EN.
module mic_sample_filter
    import mic_pkg::*;
#(
    parameter int AVG_LOG2 = 3,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inValid,
    input  logic [DATA_W-1:0] inData,
    output logic              outStart,
    output logic [DATA_W-1:0] outData,
    input  logic              dacDone,
    output logic              overrun
);

    localparam int SUM_W = DATA_W + AVG_LOG2;

    mic_state_e        state_q, state_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [SUM_W-1:0]  sum_q, sum_d, sum_acc;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              overrun_q, overrun_d;
    logic              accept;
    logic              ring_wr_en;
    logic [DATA_W-1:0] ring_oldest;
    logic [DATA_W-1:0] avg;
    logic [DATA_W-1:0] filtered;

    mic_sample_ring #(
        .DEPTH_LOG2(AVG_LOG2),
        .DATA_W    (DATA_W)
    ) u_ring (
        .clock      (clock),
        .reset      (reset),
        .wr_en_i    (ring_wr_en),
        .wr_data_i  (sample_q),
        .rd_oldest_o(ring_oldest)
    );

    // The oldest entry is part of sum_q, so the subtraction can never underflow.
    assign sum_acc = sum_q + SUM_W'(sample_q) - SUM_W'(ring_oldest);
    assign avg     = sum_acc[SUM_W-1:AVG_LOG2];

`ifdef MIC_SAMPLE_FILTER_DC_BLOCK_EN
    localparam int DC_W   = DATA_W + DC_SHIFT;
    localparam int FILT_W = DATA_W + 2;
    localparam logic signed [FILT_W-1:0] MID_S = FILT_W'(MIDSCALE);
    localparam logic signed [FILT_W-1:0] MAX_S = FILT_W'((1 << DATA_W) - 1);

    logic [DC_W-1:0]          dc_est_q, dc_est_d;
    logic [DATA_W-1:0]        dc_mean;
    logic signed [FILT_W-1:0] filt_s;

    assign dc_mean = dc_est_q[DC_W-1:DC_SHIFT];

    always_comb begin
        dc_est_d = dc_est_q;
        if (state_q == ST_ACCUM) begin
            dc_est_d = dc_est_q + DC_W'(avg) - DC_W'(dc_mean);
        end
        filt_s = $signed({2'b00, avg}) - $signed({2'b00, dc_mean}) + MID_S;
        if (filt_s[FILT_W-1]) begin
            filtered = '0;
        end else if (filt_s > MAX_S) begin
            filtered = '1;
        end else begin
            filtered = filt_s[DATA_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dc_est_q <= DC_W'(MIDSCALE) << DC_SHIFT;
        end else begin
            dc_est_q <= dc_est_d;
        end
    end
`else
    assign filtered = avg;
`endif

    // NOTE: every signal written here gets its default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        sum_d      = sum_q;
        out_data_d = out_data_q;
        overrun_d  = overrun_q;
        ring_wr_en = 1'b0;

        accept = inValid && ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && dacDone));
        if (accept) begin
            sample_d = inData;
        end
        if (inValid && !accept) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                ring_wr_en = 1'b1;
                sum_d      = sum_acc;
                out_data_d = filtered;
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (dacDone) begin
                    state_d = accept ? ST_ACCUM : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sample_q   <= '0;
            sum_q      <= '0;
            out_data_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            sum_q      <= sum_d;
            out_data_q <= out_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign outStart = (state_q == ST_ISSUE);
    assign outData  = out_data_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_mic_sample_filter.sv
// Scoreboard bench for mic_sample_filter; define MIC_SAMPLE_FILTER_DC_BLOCK_EN to exercise the DC stage.
`timescale 1ns/1ps
module tb_mic_sample_filter;

    localparam int AVG_LOG2 = 3;
    localparam int DATA_W   = 12;
    localparam int DEPTH    = 1 << AVG_LOG2;
    localparam int MAX_OBS  = 4096;
    localparam int BUDGET   = 20;

    logic              clock = 1'b0;
    logic              reset;
    logic              inValid;
    logic [DATA_W-1:0] inData;
    logic              outStart;
    logic [DATA_W-1:0] outData;
    logic              dacDone;
    logic              overrun;

    typedef struct {
        int data;
        int cyc;
        bit check_data;
    } exp_t;

    exp_t exp_q[$];
    int   hist[DEPTH];
    int   hidx;

    int cyc      = 0;
    int n_starts = 0;
    int obs_data[MAX_OBS];
    int obs_cyc[MAX_OBS];
    int rd_idx;
    int n_checks;
    int n_pass;

    mic_sample_filter #(
        .AVG_LOG2(AVG_LOG2),
        .DATA_W  (DATA_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .inValid (inValid),
        .inData  (inData),
        .outStart(outStart),
        .outData (outData),
        .dacDone (dacDone),
        .overrun (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: records every conversion request with its cycle stamp.
    always @(negedge clock) begin
        if (!reset && outStart) begin
            if (n_starts < MAX_OBS) begin
                obs_data[n_starts] <= int'(outData);
                obs_cyc[n_starts]  <= cyc;
            end
            n_starts <= n_starts + 1;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) hist[i] = 0;
        hidx = 0;
    endtask

    function automatic int model_push(input int s);
        int sum;
        hist[hidx] = s;
        hidx = (hidx + 1) % DEPTH;
        sum = 0;
        for (int i = 0; i < DEPTH; i++) sum += hist[i];
        return sum / DEPTH;
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset   = 1'b1;
        inValid = 1'b0;
        dacDone = 1'b0;
        inData  = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        model_clear();
        exp_q.delete();
        rd_idx = n_starts;
    endtask

    // Drives one accepted sample and pushes its expected output (due 2 cycles later).
    task automatic send(input int s, input bit check_data);
        exp_t e;
        @(negedge clock);
        inValid = 1'b1;
        inData  = DATA_W'(s);
        e.data       = model_push(s);
        e.cyc        = cyc + 2;
        e.check_data = check_data;
        exp_q.push_back(e);
        @(negedge clock);
        inValid = 1'b0;
    endtask

    task automatic dac_done();
        @(negedge clock);
        dacDone = 1'b1;
        @(negedge clock);
        dacDone = 1'b0;
    endtask

    // Scoreboard pop: waits (bounded) for the next outStart and compares it.
    task automatic sb_pop(input string name);
        exp_t e;
        int   waited = 0;
        while (n_starts <= rd_idx && waited < BUDGET) begin
            @(negedge clock);
            #1;
            waited++;
        end
        n_checks++;
        if (n_starts <= rd_idx) begin
            $display("FAIL %s: no outStart within %0d cycles", name, BUDGET);
            return;
        end
        if (exp_q.size() == 0) begin
            $display("FAIL %s: unexpected outStart, outData=%0d", name, obs_data[rd_idx]);
            rd_idx++;
            return;
        end
        e = exp_q.pop_front();
        if (obs_cyc[rd_idx] !== e.cyc) begin
            $display("FAIL %s latency: outStart at cycle %0d, expected %0d", name, obs_cyc[rd_idx], e.cyc);
        end else begin
            n_pass++;
        end
        if (e.check_data) begin
            n_checks++;
            if (obs_data[rd_idx] !== e.data) begin
                $display("FAIL %s data: outData=%0d, expected %0d", name, obs_data[rd_idx], e.data);
            end else begin
                n_pass++;
            end
        end
        rd_idx++;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clock);
        n_checks++;
        if (outData !== '0) $display("FAIL reset outData: got %0d, expected 0", outData);
        else n_pass++;
        n_checks++;
        if (outStart !== 1'b0) $display("FAIL reset outStart: got %b, expected 0", outStart);
        else n_pass++;
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL reset overrun: got %b, expected 0", overrun);
        else n_pass++;
    endtask

    task automatic test_average();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            send(800, 1'b1);
            sb_pop($sformatf("avg%0d", i));
            dac_done();
        end
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL avg overrun: got %b, expected 0", overrun);
        else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            send(4095, 1'b1);
            sb_pop($sformatf("wrap%0d", i));
            dac_done();
        end
        n_checks++;
        if (outData !== 12'd4095) $display("FAIL wrap final: outData=%0d, expected 4095", outData);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        apply_reset();
        send(1600, 1'b1);
        sb_pop("b2b first");
        @(negedge clock);
        dacDone = 1'b1;
        inValid = 1'b1;
        inData  = 12'd2400;
        e.data       = model_push(2400);
        e.cyc        = cyc + 2;
        e.check_data = 1'b1;
        exp_q.push_back(e);
        @(negedge clock);
        dacDone = 1'b0;
        inValid = 1'b0;
        sb_pop("b2b second");
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL b2b overrun: got %b, expected 0", overrun);
        else n_pass++;
        dac_done();
    endtask

    task automatic test_overrun();
        apply_reset();
        send(1000, 1'b1);
        inValid = 1'b1;
        inData  = 12'd3000;
        @(negedge clock);
        inValid = 1'b0;
        sb_pop("ovr first");
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL ovr sticky: got %b, expected 1", overrun);
        else n_pass++;
        dac_done();
        repeat (6) @(negedge clock);
        #1;
        n_checks++;
        if (n_starts !== rd_idx) $display("FAIL ovr extra starts: got %0d, expected %0d", n_starts, rd_idx);
        else n_pass++;
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL ovr still set: got %b, expected 1", overrun);
        else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        send(2000, 1'b1);
        sb_pop("rst_wait pre");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        dac_done();
        repeat (4) @(negedge clock);
        #1;
        n_checks++;
        if (n_starts !== rd_idx) $display("FAIL rst_wait spurious start: got %0d starts, expected %0d", n_starts, rd_idx);
        else n_pass++;
        n_checks++;
        if (outData !== '0) $display("FAIL rst_wait outData: got %0d, expected 0", outData);
        else n_pass++;
        send(1000, 1'b1);
        sb_pop("rst_wait post");
        n_checks++;
        if (outData !== 12'd125) $display("FAIL rst_wait shifted: outData=%0d, expected 125", outData);
        else n_pass++;
        dac_done();
    endtask

    task automatic test_dc_block();
        int last;
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            send(3000, 1'b0);
            sb_pop($sformatf("dc%0d", i));
            dac_done();
        end
        last = obs_data[(rd_idx - 1) % MAX_OBS];
        n_checks++;
        if (last < 2044 || last > 2052) $display("FAIL dc converge: outData=%0d, expected 2044..2052", last);
        else n_pass++;
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL dc overrun: got %b, expected 0", overrun);
        else n_pass++;
    endtask

    initial begin
        reset    = 1'b1;
        inValid  = 1'b0;
        inData   = '0;
        dacDone  = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        rd_idx   = 0;
        model_clear();

        test_reset();
`ifdef MIC_SAMPLE_FILTER_DC_BLOCK_EN
        test_dc_block();
`else
        test_average();
        test_wrap();
        test_back_to_back();
        test_overrun();
        test_reset_in_wait();
`endif
        n_checks++;
        if (n_starts !== rd_idx) $display("FAIL trailing starts: got %0d, expected %0d", n_starts, rd_idx);
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
